// File: rtl/csr_timer_int_ctrl.sv
`default_nettype none
// csr_timer_int_ctrl: stable timer (TCFG/TVAL), ESTAT.IS composition, and a
// registered interrupt request with priority index for the commit stage.
module csr_timer_int_ctrl #(
  parameter int TIMESIZE = 12
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [12:0] ecfg_lie,
  input  logic        crmd_ie,
  input  logic [7:0]  hwi,
  input  logic        ipi,
  input  logic        int_take,
  output logic [31:0] tcfg_q,
  output logic [31:0] tval_q,
  output logic [12:0] estat_is_q,
  output logic        int_req,
  output logic [3:0]  int_idx
);

  localparam logic [13:0] ADDR_ESTAT = 14'h005;
  localparam logic [13:0] ADDR_TCFG  = 14'h041;
  localparam logic [13:0] ADDR_TICLR = 14'h044;
  localparam logic [TIMESIZE-1:0] TVAL_ONE = TIMESIZE'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [TIMESIZE+1:0] tcfg;
  logic [TIMESIZE-1:0] tval;
  logic [1:0]          sw_is;
  logic                ti;
  logic [7:0]          hwi_meta;
  logic [7:0]          hwi_sync;
  logic                ipi_meta;
  logic                ipi_sync;
  state_t              state;
  state_t              state_nxt;

  logic                tcfg_wr;
  logic                ticlr_wr;
  logic                estat_wr;
  logic [TIMESIZE-1:0] init_val;
  logic                timer_en;
  logic                timer_periodic;
  logic                ti_fire;
  logic [12:0]         masked;
  logic                pending;
  logic                unused_wdata;

  assign tcfg_wr        = csr_we && (csr_waddr == ADDR_TCFG);
  assign ticlr_wr       = csr_we && (csr_waddr == ADDR_TICLR);
  assign estat_wr       = csr_we && (csr_waddr == ADDR_ESTAT);
  assign init_val       = tcfg[TIMESIZE+1:2];
  assign timer_en       = tcfg[0];
  assign timer_periodic = tcfg[1];
  // TI fires only on the 1->0 step, so InitVal=0 and a parked one-shot stay quiet.
  assign ti_fire        = timer_en && (tval == TVAL_ONE);
  assign unused_wdata   = ^csr_wdata[31:TIMESIZE+2];

  always_ff @(posedge aclk) begin
    if (reset) begin
      tcfg  <= '0;
      tval  <= '0;
      ti    <= 1'b0;
      sw_is <= 2'b00;
    end else begin
      if (tcfg_wr) begin
        tcfg <= csr_wdata[TIMESIZE+1:0];
      end
      if (tcfg_wr) begin
        tval <= csr_wdata[TIMESIZE+1:2];
      end else if (timer_en) begin
        if (tval != '0) begin
          tval <= tval - TVAL_ONE;
        end else if (timer_periodic) begin
          tval <= init_val;
        end
      end
      // An expiry in the same cycle as a TICLR write keeps TI set.
      if (ti_fire) begin
        ti <= 1'b1;
      end else if (ticlr_wr && csr_wdata[0]) begin
        ti <= 1'b0;
      end
      if (estat_wr) begin
        sw_is <= csr_wdata[1:0];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      hwi_meta <= 8'h00;
      hwi_sync <= 8'h00;
      ipi_meta <= 1'b0;
      ipi_sync <= 1'b0;
    end else begin
      hwi_meta <= hwi;
      hwi_sync <= hwi_meta;
      ipi_meta <= ipi;
      ipi_sync <= ipi_meta;
    end
  end

  assign tcfg_q     = 32'(tcfg);
  assign tval_q     = 32'(tval);
  assign estat_is_q = {ipi_sync, ti, 1'b0, hwi_sync, sw_is};

  assign masked  = estat_is_q & ecfg_lie;
  assign pending = crmd_ie && (|masked);

  always_comb begin
    int_idx = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (masked[i]) begin
        int_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pending) state_nxt = S_REQ;
      S_REQ: begin
        if (int_take) begin
          state_nxt = S_HOLD;
        end else if (!pending) begin
          state_nxt = S_IDLE;
        end
      end
      // The exit edge of HOLD already performs IDLE's evaluation, so the
      // request is low for exactly one cycle when the source is still pending.
      S_HOLD:  state_nxt = pending ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign int_req = (state == S_REQ);

endmodule
`default_nettype wire
